// File: rtl/queen_backtrack_ctrl.sv
// queen_backtrack_ctrl
//   Iterative N-queens backtracking sequencer. A per-row column stack is
//   searched depth first. Each candidate is checked against one earlier row
//   per cycle. Every solution is streamed row by row under a valid/ack
//   handshake. The block then parks until 'next' resumes the search. When
//   the search is exhausted it reports the number of solutions found.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous, active-high
//   start      level, sampled in IDLE/DONE; begins a fresh search
//   ready      high in IDLE and DONE
//   busy       high in CHECK, ADVANCE, BACKTRACK, EMIT, WAIT_NEXT
//   sol_valid  high in EMIT
//   sol_ack    consumer accepts the current beat when sol_valid is high
//   out_bus    one-hot column of row out_row; 0 outside EMIT
//   out_row    row index of the current beat; 0 outside EMIT
//   next       sampled in WAIT_NEXT; resumes the search
//   done       high in DONE
//   sol_count  solutions found since the last start
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | after reset, waiting for start
// CHECK     | compare col[row] against col[k]; k == row means placement safe
// ADVANCE   | move the queen of the current row one column right
// BACKTRACK | current row exhausted, step back one row
// EMIT      | stream the solution, one row per accepted beat
// WAIT_NEXT | solution streamed, waiting for next
// DONE      | search exhausted, sol_count final
module queen_backtrack_ctrl #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       ready,
  output logic       busy,
  output logic       sol_valid,
  input  logic       sol_ack,
  output logic [7:0] out_bus,
  output logic [2:0] out_row,
  input  logic       next,
  output logic       done,
  output logic [7:0] sol_count
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ADVANCE,
    BACKTRACK,
    EMIT,
    WAIT_NEXT,
    DONE
  } state_t;

  localparam logic [2:0] LAST = 3'(N - 1);

  state_t     state, state_nxt;
  logic [2:0] row, k, beat;
  // Sized for the largest legal board so any 3-bit index stays in range.
  logic [2:0] col [8];

  logic [2:0] col_row, col_k;
  logic [3:0] col_dist, row_dist;
  logic       safe, conflict, last_row, col_max, last_beat;

  assign col_row   = col[row];
  assign col_k     = col[k];
  // Unsigned distances widened to 4 bits so neither subtraction can wrap.
  assign col_dist  = (col_row >= col_k) ? ({1'b0, col_row} - {1'b0, col_k})
                                        : ({1'b0, col_k} - {1'b0, col_row});
  assign row_dist  = {1'b0, row} - {1'b0, k};
  assign safe      = (k == row);
  assign conflict  = !safe && ((col_row == col_k) || (col_dist == row_dist));
  assign last_row  = (row == LAST);
  assign col_max   = (col_row == LAST);
  assign last_beat = (beat == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    sol_valid = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = CHECK;
      end
      CHECK: begin
        busy = 1'b1;
        if (safe && last_row) state_nxt = EMIT;
        else if (conflict)    state_nxt = ADVANCE;
      end
      ADVANCE: begin
        busy = 1'b1;
        state_nxt = col_max ? BACKTRACK : CHECK;
      end
      BACKTRACK: begin
        busy = 1'b1;
        state_nxt = (row == 3'd0) ? DONE : ADVANCE;
      end
      EMIT: begin
        busy      = 1'b1;
        sol_valid = 1'b1;
        if (sol_ack && last_beat) state_nxt = WAIT_NEXT;
      end
      WAIT_NEXT: begin
        busy = 1'b1;
        if (next) state_nxt = ADVANCE;
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) state_nxt = CHECK;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from state so an asynchronous reset clears them
  // within the same cycle.
  assign out_row = sol_valid ? beat : 3'd0;
  assign out_bus = sol_valid ? (8'd1 << col[beat]) : 8'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row       <= 3'd0;
      k         <= 3'd0;
      beat      <= 3'd0;
      sol_count <= 8'd0;
      for (int i = 0; i < 8; i++) col[i] <= 3'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            row       <= 3'd0;
            k         <= 3'd0;
            col[0]    <= 3'd0;
            sol_count <= 8'd0;
          end
        end
        CHECK: begin
          if (safe) begin
            if (last_row) begin
              sol_count <= sol_count + 8'd1;
              beat      <= 3'd0;
            end else begin
              row            <= row + 3'd1;
              col[row + 3'd1] <= 3'd0;
              k              <= 3'd0;
            end
          end else if (!conflict) begin
            k <= k + 3'd1;
          end
        end
        ADVANCE: begin
          if (!col_max) begin
            col[row] <= col_row + 3'd1;
            k        <= 3'd0;
          end
        end
        BACKTRACK: begin
          if (row != 3'd0) row <= row - 3'd1;
        end
        EMIT: begin
          if (sol_ack && !last_beat) beat <= beat + 3'd1;
        end
        WAIT_NEXT: begin
          // Resume from the deepest row so ADVANCE moves past this solution.
          if (next) row <= LAST;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_queen_backtrack_ctrl.sv
module tb_queen_backtrack_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;

  logic       start8 = 0, ack8 = 0, next8 = 0;
  logic       ready8, busy8, valid8, done8;
  logic [7:0] bus8, cnt8;
  logic [2:0] row8;

  logic       start4 = 0, ack4 = 0, next4 = 0;
  logic       ready4, busy4, valid4, done4;
  logic [7:0] bus4, cnt4;
  logic [2:0] row4;

  logic       start3 = 0, ack3 = 0, next3 = 0;
  logic       ready3, busy3, valid3, done3;
  logic [7:0] bus3, cnt3;
  logic [2:0] row3;

  logic       start1 = 0, ack1 = 0, next1 = 0;
  logic       ready1, busy1, valid1, done1;
  logic [7:0] bus1, cnt1;
  logic [2:0] row1;

  int passed = 0;
  int total  = 0;

  logic [7:0] first8 [8] = '{8'h01, 8'h10, 8'h80, 8'h20, 8'h04, 8'h40, 8'h02, 8'h08};
  logic [7:0] sol4 [2][4] = '{'{8'h02, 8'h08, 8'h01, 8'h04}, '{8'h04, 8'h01, 8'h08, 8'h02}};

  queen_backtrack_ctrl #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .ready(ready8), .busy(busy8),
    .sol_valid(valid8), .sol_ack(ack8), .out_bus(bus8), .out_row(row8),
    .next(next8), .done(done8), .sol_count(cnt8));

  queen_backtrack_ctrl #(.N(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .ready(ready4), .busy(busy4),
    .sol_valid(valid4), .sol_ack(ack4), .out_bus(bus4), .out_row(row4),
    .next(next4), .done(done4), .sol_count(cnt4));

  queen_backtrack_ctrl #(.N(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .ready(ready3), .busy(busy3),
    .sol_valid(valid3), .sol_ack(ack3), .out_bus(bus3), .out_row(row3),
    .next(next3), .done(done3), .sol_count(cnt3));

  queen_backtrack_ctrl #(.N(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .ready(ready1), .busy(busy1),
    .sol_valid(valid1), .sol_ack(ack1), .out_bus(bus1), .out_row(row1),
    .next(next1), .done(done1), .sol_count(cnt1));

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1; start8 = 0; ack8 = 0; next8 = 0;
    start4 = 0; ack4 = 0; next4 = 0; start3 = 0; ack3 = 0; next3 = 0;
    start1 = 0; ack1 = 0; next1 = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_start8;
    @(negedge clk); start8 = 1'b1;
    @(negedge clk); start8 = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (ready8 !== 1'b1 || busy8 !== 1'b0 || valid8 !== 1'b0 || done8 !== 1'b0)
      $display("FAIL reset_flags: ready=%b busy=%b valid=%b done=%b, expected 1 0 0 0", ready8, busy8, valid8, done8);
    else passed++;
    total++;
    if (bus8 !== 8'h00 || row8 !== 3'd0 || cnt8 !== 8'h00)
      $display("FAIL reset_data: bus=%h row=%0d cnt=%0d, expected 00 0 0", bus8, row8, cnt8);
    else passed++;
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (ready8 !== 1'b1 || busy8 !== 1'b0)
      $display("FAIL idle_hold: ready=%b busy=%b, expected 1 0", ready8, busy8);
    else passed++;
  endtask

  task automatic test_first_solution;
    bit found = 0;
    do_reset;
    ack8 = 1'b1;
    pulse_start8;
    total++;
    if (busy8 !== 1'b1 || ready8 !== 1'b0)
      $display("FAIL start_busy: busy=%b ready=%b, expected 1 0", busy8, ready8);
    else passed++;
    for (int c = 0; c < 20000 && !found; c++) begin
      if (valid8) found = 1; else @(negedge clk);
    end
    total++;
    if (!found) begin $display("FAIL first_timeout: sol_valid=0, expected 1"); return; end
    passed++;
    total++;
    if (cnt8 !== 8'd1) $display("FAIL first_count: cnt=%0d, expected 1", cnt8); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (valid8 !== 1'b1 || row8 !== 3'(i) || bus8 !== first8[i])
        $display("FAIL first_beat%0d: valid=%b row=%0d bus=%h, expected 1 %0d %h", i, valid8, row8, bus8, i, first8[i]);
      else passed++;
      @(negedge clk);
    end
    for (int h = 0; h < 3; h++) begin
      total++;
      if (busy8 !== 1'b1 || valid8 !== 1'b0 || bus8 !== 8'h00 || row8 !== 3'd0)
        $display("FAIL wait_next%0d: busy=%b valid=%b bus=%h row=%0d, expected 1 0 00 0", h, busy8, valid8, bus8, row8);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    bit found = 0;
    do_reset;
    ack8 = 1'b1;
    pulse_start8;
    for (int c = 0; c < 20000 && !found; c++) begin
      if (valid8) found = 1; else @(negedge clk);
    end
    total++;
    if (!found) begin $display("FAIL bp_timeout: sol_valid=0, expected 1"); return; end
    passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (row8 !== 3'(i) || bus8 !== first8[i])
        $display("FAIL bp_beat%0d: row=%0d bus=%h, expected %0d %h", i, row8, bus8, i, first8[i]);
      else passed++;
      @(negedge clk);
    end
    ack8 = 1'b0;
    for (int h = 0; h <= 5; h++) begin
      if (h == 5) ack8 = 1'b1;
      total++;
      if (valid8 !== 1'b1 || row8 !== 3'd3 || bus8 !== 8'h20)
        $display("FAIL bp_hold%0d: valid=%b row=%0d bus=%h, expected 1 3 20", h, valid8, row8, bus8);
      else passed++;
      @(negedge clk);
    end
    for (int i = 4; i < 8; i++) begin
      total++;
      if (valid8 !== 1'b1 || row8 !== 3'(i) || bus8 !== first8[i])
        $display("FAIL bp_beat%0d: valid=%b row=%0d bus=%h, expected 1 %0d %h", i, valid8, row8, bus8, i, first8[i]);
      else passed++;
      @(negedge clk);
    end
    total++;
    if (valid8 !== 1'b0 || busy8 !== 1'b1 || cnt8 !== 8'd1)
      $display("FAIL bp_end: valid=%b busy=%b cnt=%0d, expected 0 1 1", valid8, busy8, cnt8);
    else passed++;
  endtask

  task automatic test_reset_mid;
    bit found = 0;
    do_reset;
    ack8 = 1'b1;
    pulse_start8;
    #2 reset = 1'b1;
    #1;
    total++;
    if (ready8 !== 1'b1 || busy8 !== 1'b0 || valid8 !== 1'b0 || cnt8 !== 8'd0)
      $display("FAIL rst_check: ready=%b busy=%b valid=%b cnt=%0d, expected 1 0 0 0", ready8, busy8, valid8, cnt8);
    else passed++;
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    total++;
    if (ready8 !== 1'b1 || busy8 !== 1'b0)
      $display("FAIL rst_check_idle: ready=%b busy=%b, expected 1 0", ready8, busy8);
    else passed++;
    pulse_start8;
    for (int c = 0; c < 20000 && !found; c++) begin
      if (valid8) found = 1; else @(negedge clk);
    end
    total++;
    if (!found) begin $display("FAIL rst_emit_timeout: sol_valid=0, expected 1"); return; end
    passed++;
    repeat (4) @(negedge clk);
    total++;
    if (row8 !== 3'd4 || bus8 !== 8'h04)
      $display("FAIL rst_emit_beat4: row=%0d bus=%h, expected 4 04", row8, bus8);
    else passed++;
    #2 reset = 1'b1;
    #1;
    total++;
    if (ready8 !== 1'b1 || valid8 !== 1'b0 || bus8 !== 8'h00 || row8 !== 3'd0 || cnt8 !== 8'd0)
      $display("FAIL rst_emit: ready=%b valid=%b bus=%h row=%0d cnt=%0d, expected 1 0 00 0 0", ready8, valid8, bus8, row8, cnt8);
    else passed++;
    @(negedge clk); reset = 1'b0;
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      total++;
      if (valid8 !== 1'b0 || ready8 !== 1'b1)
        $display("FAIL rst_no_resume%0d: valid=%b ready=%b, expected 0 1", h, valid8, ready8);
      else passed++;
    end
    found = 0;
    pulse_start8;
    for (int c = 0; c < 20000 && !found; c++) begin
      if (valid8) found = 1; else @(negedge clk);
    end
    total++;
    if (!found) begin $display("FAIL rst_restart_timeout: sol_valid=0, expected 1"); return; end
    passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (row8 !== 3'(i) || bus8 !== first8[i])
        $display("FAIL rst_restart_beat%0d: row=%0d bus=%h, expected %0d %h", i, row8, bus8, i, first8[i]);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_all_solutions;
    bit         found;
    bit         ok;
    bit         extra;
    int         cols [8];
    logic [23:0] prev, cur;
    do_reset;
    ack8 = 1'b1;
    pulse_start8;
    prev = 24'd0;
    for (int s = 0; s < 92; s++) begin
      found = 0;
      for (int c = 0; c < 20000 && !found; c++) begin
        if (valid8) found = 1; else @(negedge clk);
      end
      total++;
      if (!found) begin $display("FAIL all_timeout: stream %0d missing", s); return; end
      passed++;
      ok = 1;
      for (int i = 0; i < 8; i++) begin
        if (valid8 !== 1'b1 || row8 !== 3'(i) || !$onehot(bus8)) ok = 0;
        cols[i] = 0;
        for (int j = 0; j < 8; j++) if (bus8[j]) cols[i] = j;
        @(negedge clk);
      end
      for (int a = 0; a < 8; a++)
        for (int b = a + 1; b < 8; b++)
          if (cols[a] == cols[b] || cols[b] - cols[a] == b - a || cols[a] - cols[b] == b - a) ok = 0;
      cur = 24'd0;
      for (int i = 0; i < 8; i++) cur = {cur[20:0], 3'(cols[i])};
      total++;
      if (!ok) $display("FAIL all_valid: stream %0d cols=%h is not a queen set", s, cur);
      else passed++;
      if (s > 0) begin
        total++;
        if (cur <= prev) $display("FAIL all_order: stream %0d cols=%h, expected above %h", s, cur, prev);
        else passed++;
      end
      prev = cur;
      total++;
      if (cnt8 !== 8'(s + 1) || valid8 !== 1'b0)
        $display("FAIL all_count: stream %0d cnt=%0d valid=%b, expected %0d 0", s, cnt8, valid8, s + 1);
      else passed++;
      next8 = 1'b1;
      @(negedge clk);
      next8 = 1'b0;
    end
    found = 0;
    extra = 0;
    for (int c = 0; c < 20000 && !found; c++) begin
      if (valid8) extra = 1;
      if (done8) found = 1; else @(negedge clk);
    end
    total++;
    if (!found || extra)
      $display("FAIL all_done: done_seen=%b extra_stream=%b, expected 1 0", found, extra);
    else passed++;
    total++;
    if (done8 !== 1'b1 || ready8 !== 1'b1 || busy8 !== 1'b0 || cnt8 !== 8'h5C)
      $display("FAIL all_final: done=%b ready=%b busy=%b cnt=%h, expected 1 1 0 5c", done8, ready8, busy8, cnt8);
    else passed++;
  endtask

  task automatic test_n4;
    bit found;
    @(negedge clk); ack4 = 1'b1; start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    for (int s = 0; s < 2; s++) begin
      found = 0;
      for (int c = 0; c < 2000 && !found; c++) begin
        if (valid4) found = 1; else @(negedge clk);
      end
      total++;
      if (!found) begin $display("FAIL n4_timeout: stream %0d missing", s); return; end
      passed++;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (row4 !== 3'(i) || bus4 !== sol4[s][i])
          $display("FAIL n4_beat%0d_%0d: row=%0d bus=%h, expected %0d %h", s, i, row4, bus4, i, sol4[s][i]);
        else passed++;
        @(negedge clk);
      end
      total++;
      if (cnt4 !== 8'(s + 1) || valid4 !== 1'b0 || busy4 !== 1'b1)
        $display("FAIL n4_wait%0d: cnt=%0d valid=%b busy=%b, expected %0d 0 1", s, cnt4, valid4, busy4, s + 1);
      else passed++;
      if (s == 0) begin
        start4 = 1'b1;
        @(negedge clk); @(negedge clk);
        start4 = 1'b0;
        total++;
        if (busy4 !== 1'b1 || ready4 !== 1'b0 || valid4 !== 1'b0 || cnt4 !== 8'd1)
          $display("FAIL n4_start_ignored: busy=%b ready=%b valid=%b cnt=%0d, expected 1 0 0 1", busy4, ready4, valid4, cnt4);
        else passed++;
      end
      next4 = 1'b1;
      @(negedge clk);
      next4 = 1'b0;
    end
    found = 0;
    for (int c = 0; c < 2000 && !found; c++) begin
      if (done4) found = 1; else @(negedge clk);
    end
    total++;
    if (!found || ready4 !== 1'b1 || cnt4 !== 8'd2 || valid4 !== 1'b0)
      $display("FAIL n4_done: done=%b ready=%b cnt=%0d valid=%b, expected 1 1 2 0", done4, ready4, cnt4, valid4);
    else passed++;
  endtask

  task automatic test_restart_from_done;
    bit found = 0;
    start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
    total++;
    if (cnt4 !== 8'd0 || busy4 !== 1'b1 || done4 !== 1'b0)
      $display("FAIL restart_state: cnt=%0d busy=%b done=%b, expected 0 1 0", cnt4, busy4, done4);
    else passed++;
    for (int c = 0; c < 2000 && !found; c++) begin
      if (valid4) found = 1; else @(negedge clk);
    end
    total++;
    if (!found) begin $display("FAIL restart_timeout: sol_valid=0, expected 1"); return; end
    passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (row4 !== 3'(i) || bus4 !== sol4[0][i])
        $display("FAIL restart_beat%0d: row=%0d bus=%h, expected %0d %h", i, row4, bus4, i, sol4[0][i]);
      else passed++;
      @(negedge clk);
    end
  endtask

  task automatic test_n3;
    bit found = 0;
    bit saw_valid = 0;
    @(negedge clk); ack3 = 1'b1; start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      if (valid3) saw_valid = 1;
      if (done3) found = 1; else @(negedge clk);
    end
    total++;
    if (!found || saw_valid)
      $display("FAIL n3_done: done_seen=%b valid_seen=%b, expected 1 0", found, saw_valid);
    else passed++;
    total++;
    if (cnt3 !== 8'd0 || ready3 !== 1'b1)
      $display("FAIL n3_count: cnt=%0d ready=%b, expected 0 1", cnt3, ready3);
    else passed++;
  endtask

  task automatic test_n1;
    bit found = 0;
    @(negedge clk); ack1 = 1'b1; start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (valid1) found = 1; else @(negedge clk);
    end
    total++;
    if (!found || bus1 !== 8'h01 || row1 !== 3'd0 || cnt1 !== 8'd1)
      $display("FAIL n1_emit: valid=%b bus=%h row=%0d cnt=%0d, expected 1 01 0 1", found, bus1, row1, cnt1);
    else passed++;
    @(negedge clk);
    next1 = 1'b1;
    @(negedge clk);
    next1 = 1'b0;
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      if (done1) found = 1; else @(negedge clk);
    end
    total++;
    if (!found || cnt1 !== 8'd1 || valid1 !== 1'b0)
      $display("FAIL n1_done: done=%b cnt=%0d valid=%b, expected 1 1 0", done1, cnt1, valid1);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_first_solution;
    test_backpressure;
    test_reset_mid;
    test_all_solutions;
    test_n4;
    test_restart_from_done;
    test_n3;
    test_n1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
